lcd_bus_responder: RTL and testbench
====================================

// Module: lcd_bus_responder
// PURPOSE
//  HD44780-compatible responder on the far end of the 8-bit LCD bus (lcd_d/lcd_rs/lcd_rw/lcd_e) driven by picoblaze_template.
//  Decodes instruction and data writes, keeps a 2x16 DDRAM shadow and answers busy-flag/address and data reads.
//  Used as a bench/board display model and as a shadow copy that other logic can read back.
// PARAMETERS
//  CLK_FREQ_HZ   25000000  clk frequency; converts the busy times below into cycles
//  BUSY_US       40        busy time after any accepted write except clear/home
//  CLEAR_BUSY_US 1640      busy time after clear display (0x01) or return home (0x02/0x03)
// PORTS
//  clk          in   1  system clock (CLK_25 domain)
//  reset        in   1  asynchronous, active-low reset
//  lcd_e        in   1  bus enable, asynchronous to clk
//  lcd_rs       in   1  0 = instruction, 1 = data
//  lcd_rw       in   1  0 = write, 1 = read
//  lcd_d_in     in   8  bus data from the initiator
//  lcd_d_out    out  8  read data driven back onto the bus
//  lcd_d_oe     out  1  1 = responder drives lcd_d
//  rd_addr      in   5  shadow read index: 0-15 line 0, 16-31 line 1
//  rd_char      out  8  shadow[rd_addr], registered, 1-cycle latency
//  busy         out  1  internal busy flag
//  ac           out  7  address counter
//  display_on   out  1  D bit from the last display-control write
//  wr_strobe    out  1  1-cycle pulse for each accepted write
//  wr_is_data   out  1  RS of the last accepted write
//  wr_byte      out  8  byte of the last accepted write
//  overrun      out  1  sticky: a write arrived while busy
// BEHAVIOUR
//  - Reset: every output is 0 except rd_char=0x20. Shadow = 0x20, ac=0, inc mode=1, busy=0, mode=DDRAM.
//  - Input sync: lcd_e/rs/rw/d_in pass through a 2-flop synchroniser. Strobe event = falling edge of synced E.
//    RS/RW/D are sampled on the clk where the falling edge is detected.
//  - Write event (rw=0), processed when busy=0:
//    - wr_strobe pulses on the next cycle.
//    - busy loads BUSY_US*CLK_FREQ_HZ/1e6 cycles, or the CLEAR value for 0x01/0x02/0x03, and counts down to 0.
//  - Write event while busy=1: ignored (no strobe, no state change) and overrun is set. Only reset clears overrun.
//  - Instruction decode, priority is the highest set bit:
//    - 1xxxxxxx: ac = d[6:0]; mode = DDRAM.
//    - 01xxxxxx: mode = CGRAM; cg_addr = d[5:0].
//    - 001xxxxx (function set) and 0001xxxx (shift): no state change except busy.
//    - 00001DCB: display_on = D.
//    - 000001IS: inc = I.
//    - 0000001x: ac = 0.
//    - 00000001: ac = 0, inc = 1; shadow fill with 0x20 at 1 entry per cycle (32 cycles, inside the busy window).
//  - Data write in DDRAM mode:
//    - ac 0x00-0x0F -> shadow[ac]; ac 0x40-0x4F -> shadow[16+ac-0x40]; other ac values are discarded.
//    - ac always steps: inc -> 0x27->0x40, 0x67->0x00; dec -> 0x40->0x27, 0x00->0x67.
//    - Any ac value outside 0x00-0x27 and 0x40-0x67 maps to the next legal value in that direction.
//  - Read (rw=1):
//    - lcd_d_oe=1 while synced E=1 and rw=1; 0 otherwise.
//    - rs=0: lcd_d_out = {busy, ac}. Reads are accepted while busy.
//    - rs=1: lcd_d_out = shadow char at ac (0x20 if unmapped); ac steps on E falling edge.
//    - A data read while busy returns the value but does not step ac.
//  - Shadow port: rd_char updates 1 cycle after rd_addr changes. rd_addr >= 32 returns 0x20.
//    If rd_addr hits the entry being written in the same cycle, the new value appears the following cycle.
//  - Reset mid-fill or mid-busy: everything returns to reset values immediately (asynchronous).
// CONFIGURATION
//  LCD_RESP_CGRAM_EN defined:
//    - 64x5-bit CGRAM is stored; data writes in CGRAM mode write d[4:0] at cg_addr; cg_addr increments mod 64.
//    - Data reads in CGRAM mode return {3'b000, cgram[cg_addr]}.
//  LCD_RESP_CGRAM_EN not defined: CGRAM-mode data writes are discarded (strobe and busy still occur); reads return 0x00.
// TESTING
//  T1 reset low at t=0, release -> all outputs 0, rd_char=0x20 for rd_addr 0..31; busy=0.
//  T2 write 0x80 then data 0x48 ('H') -> shadow[0]=0x48, ac=0x01, wr_strobe pulses twice, busy high 1000 cycles at 25 MHz.
//  T3 write 0xCF, data 0x41, data 0x42 -> shadow[31]=0x41, 0x42 discarded (ac 0x50), ac=0x51.
//  T4 write 0x01, then a write inside the 41000-cycle busy window -> write ignored, overrun=1, all 32 entries =0x20, ac=0.
//  T5 instruction read (rs=0, rw=1) during busy -> lcd_d_oe=1 while E high, lcd_d_out[7]=1, [6:0]=ac; oe=0 after E falls.
//  T6 entry 0x04 (dec), ac=0x40, data write -> ac=0x27; with LCD_RESP_CGRAM_EN, 0x40 + data 0x1F reads back 0x1F.

Source files
------------

// File: rtl/lcd_bus_responder.sv
// HD44780-style responder for the 8-bit LCD bus: decodes writes, shadows 2x16 DDRAM, answers reads.
// Optional CGRAM storage is enabled with `define LCD_RESP_CGRAM_EN.
module lcd_bus_responder #(
    parameter int unsigned CLK_FREQ_HZ   = 25000000,
    parameter int unsigned BUSY_US       = 40,
    parameter int unsigned CLEAR_BUSY_US = 1640
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_d_in,
    output logic [7:0] lcd_d_out,
    output logic       lcd_d_oe,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic       busy,
    output logic [6:0] ac,
    output logic       display_on,
    output logic       wr_strobe,
    output logic       wr_is_data,
    output logic [7:0] wr_byte,
    output logic       overrun
);
    localparam logic [31:0] BUSY_CYC  = 32'(64'(BUSY_US) * 64'(CLK_FREQ_HZ) / 64'd1000000);
    localparam logic [31:0] CLEAR_CYC = 32'(64'(CLEAR_BUSY_US) * 64'(CLK_FREQ_HZ) / 64'd1000000);

    logic [10:0] r_sync1, r_sync2;
    logic        r_e_d;
    logic [7:0]  r_shadow [32];
    logic [6:0]  r_ac;
    logic        r_inc;
    logic        r_mode_cg;
    logic [31:0] r_busy_cnt;
    logic        r_fill_act;
    logic [4:0]  r_fill_idx;
    logic        r_disp;
    logic        r_wr_strobe;
    logic        r_wr_is_data;
    logic [7:0]  r_wr_byte;
    logic        r_overrun;
    logic [7:0]  r_rd_char;
`ifdef LCD_RESP_CGRAM_EN
    logic [4:0]  r_cgram [64];
    logic [5:0]  r_cg_addr;
`endif

    logic       w_e, w_rs, w_rw, w_fall, w_busy;
    logic       w_wr_ev, w_wr_ovr, w_rd_ev, w_clr_cmd;
    logic [7:0] w_d, w_rd_data;
    logic       w_ac_hit;
    logic [4:0] w_ac_idx;

    // Legal DDRAM addresses are 0x00-0x27 and 0x40-0x67; anything else snaps to the next legal one.
    function automatic logic [6:0] f_step(input logic [6:0] a, input logic up);
        if (up) begin
            if (a < 7'h27)       return a + 7'd1;
            else if (a < 7'h40)  return 7'h40;
            else if (a < 7'h67)  return a + 7'd1;
            else                 return 7'h00;
        end else begin
            if (a == 7'h00)      return 7'h67;
            else if (a <= 7'h27) return a - 7'd1;
            else if (a <= 7'h40) return 7'h27;
            else if (a <= 7'h67) return a - 7'd1;
            else                 return 7'h67;
        end
    endfunction

    assign w_e       = r_sync2[10];
    assign w_rs      = r_sync2[9];
    assign w_rw      = r_sync2[8];
    assign w_d       = r_sync2[7:0];
    assign w_fall    = r_e_d & ~w_e;
    assign w_busy    = (r_busy_cnt != 32'd0);
    assign w_wr_ev   = w_fall & ~w_rw & ~w_busy;
    assign w_wr_ovr  = w_fall & ~w_rw & w_busy;
    assign w_rd_ev   = w_fall & w_rw & w_rs & ~w_busy;
    assign w_clr_cmd = ~w_rs & (w_d == 8'h01 || w_d == 8'h02 || w_d == 8'h03);

    always_comb begin
        w_ac_hit = 1'b0;
        w_ac_idx = {1'b0, r_ac[3:0]};
        if (r_ac[6:4] == 3'b000) begin
            w_ac_hit = 1'b1;
        end else if (r_ac[6:4] == 3'b100) begin
            w_ac_hit = 1'b1;
            w_ac_idx = {1'b1, r_ac[3:0]};
        end
    end

    always_comb begin
        w_rd_data = 8'h20;
        if (r_mode_cg) begin
`ifdef LCD_RESP_CGRAM_EN
            w_rd_data = {3'b000, r_cgram[r_cg_addr]};
`else
            w_rd_data = 8'h00;
`endif
        end else if (w_ac_hit) begin
            w_rd_data = r_shadow[w_ac_idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_e_d        <= 1'b0;
            for (int i = 0; i < 32; i++) r_shadow[i] <= 8'h20;
            r_ac         <= '0;
            r_inc        <= 1'b1;
            r_mode_cg    <= 1'b0;
            r_busy_cnt   <= '0;
            r_fill_act   <= 1'b0;
            r_fill_idx   <= '0;
            r_disp       <= 1'b0;
            r_wr_strobe  <= 1'b0;
            r_wr_is_data <= 1'b0;
            r_wr_byte    <= '0;
            r_overrun    <= 1'b0;
            r_rd_char    <= 8'h20;
`ifdef LCD_RESP_CGRAM_EN
            for (int i = 0; i < 64; i++) r_cgram[i] <= '0;
            r_cg_addr    <= '0;
`endif
        end else begin
            r_sync1     <= {lcd_e, lcd_rs, lcd_rw, lcd_d_in};
            r_sync2     <= r_sync1;
            r_e_d       <= w_e;
            r_wr_strobe <= w_wr_ev;
            r_rd_char   <= r_shadow[rd_addr];
            if (w_wr_ovr) r_overrun <= 1'b1;

            if (w_wr_ev) begin
                r_busy_cnt   <= w_clr_cmd ? CLEAR_CYC : BUSY_CYC;
                r_wr_is_data <= w_rs;
                r_wr_byte    <= w_d;
            end else if (w_busy) begin
                r_busy_cnt   <= r_busy_cnt - 32'd1;
            end

            // Clear-display fill runs inside the busy window, so no data write can collide with it.
            if (r_fill_act) begin
                r_shadow[r_fill_idx] <= 8'h20;
                r_fill_idx           <= r_fill_idx + 5'd1;
                if (r_fill_idx == 5'd31) r_fill_act <= 1'b0;
            end

            if (w_wr_ev && !w_rs) begin
                if (w_d[7]) begin
                    r_ac      <= w_d[6:0];
                    r_mode_cg <= 1'b0;
                end else if (w_d[6]) begin
                    r_mode_cg <= 1'b1;
`ifdef LCD_RESP_CGRAM_EN
                    r_cg_addr <= w_d[5:0];
`endif
                end else if (w_d[5] || w_d[4]) begin
                    r_mode_cg <= r_mode_cg;
                end else if (w_d[3]) begin
                    r_disp <= w_d[2];
                end else if (w_d[2]) begin
                    r_inc <= w_d[1];
                end else if (w_d[1]) begin
                    r_ac <= '0;
                end else if (w_d[0]) begin
                    r_ac       <= '0;
                    r_inc      <= 1'b1;
                    r_fill_act <= 1'b1;
                    r_fill_idx <= '0;
                end
            end

            if (w_wr_ev && w_rs) begin
                if (!r_mode_cg) begin
                    if (w_ac_hit) r_shadow[w_ac_idx] <= w_d;
                    r_ac <= f_step(r_ac, r_inc);
                end
`ifdef LCD_RESP_CGRAM_EN
                else begin
                    r_cgram[r_cg_addr] <= w_d[4:0];
                    r_cg_addr          <= r_cg_addr + 6'd1;
                end
`endif
            end

            if (w_rd_ev) begin
                if (!r_mode_cg) r_ac <= f_step(r_ac, r_inc);
`ifdef LCD_RESP_CGRAM_EN
                else            r_cg_addr <= r_cg_addr + 6'd1;
`endif
            end
        end
    end

    assign lcd_d_oe   = w_e & w_rw;
    assign lcd_d_out  = w_rs ? w_rd_data : {w_busy, r_ac};
    assign rd_char    = r_rd_char;
    assign busy       = w_busy;
    assign ac         = r_ac;
    assign display_on = r_disp;
    assign wr_strobe  = r_wr_strobe;
    assign wr_is_data = r_wr_is_data;
    assign wr_byte    = r_wr_byte;
    assign overrun    = r_overrun;
endmodule

// File: tb/tb_lcd_bus_responder.sv
// Scoreboarded bench for lcd_bus_responder: write strobes are checked by a monitor against a queue,
// state and read-back values by directed checks.
module tb_lcd_bus_responder;
    logic       clk = 1'b0, reset = 1'b0;
    logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
    logic [7:0] lcd_d_in = 8'h00;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] lcd_d_out, rd_char, wr_byte;
    logic [6:0] ac;
    logic       lcd_d_oe, busy, display_on, wr_strobe, wr_is_data, overrun;

    int checks = 0, errors = 0;
    int busy_run = 0, last_busy_len = 0;
    logic [8:0] exp_q[$];

    lcd_bus_responder dut (
        .clk(clk), .reset(reset), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_d_in(lcd_d_in), .lcd_d_out(lcd_d_out), .lcd_d_oe(lcd_d_oe), .rd_addr(rd_addr),
        .rd_char(rd_char), .busy(busy), .ac(ac), .display_on(display_on), .wr_strobe(wr_strobe),
        .wr_is_data(wr_is_data), .wr_byte(wr_byte), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the next queued {rs, byte}.
    always @(negedge clk) begin
        if (reset && wr_strobe === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got %0h expected none", {wr_is_data, wr_byte});
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                chk("strobe", {23'b0, wr_is_data, wr_byte}, {23'b0, e});
            end
        end
    end

    always @(negedge clk) begin
        if (busy === 1'b1) busy_run++;
        else if (busy_run != 0) begin
            last_busy_len = busy_run;
            busy_run = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 50000) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: got busy=%0b expected 0", busy);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic bus_write(input logic rs, input logic [7:0] d, input logic accept);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = 1'b0; lcd_d_in = d;
        if (accept) exp_q.push_back({rs, d});
        repeat (2) @(negedge clk);
        lcd_e = 1'b1;
        repeat (4) @(negedge clk);
        lcd_e = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic wr(input logic rs, input logic [7:0] d);
        bus_write(rs, d, 1'b1);
        wait_idle();
    endtask

    task automatic bus_read(input logic rs, input logic [7:0] exp, input string name);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = 1'b1;
        repeat (2) @(negedge clk);
        lcd_e = 1'b1;
        repeat (4) @(negedge clk);
        chk({name, "_oe_hi"}, {31'b0, lcd_d_oe}, 32'd1);
        chk({name, "_data"}, {24'b0, lcd_d_out}, {24'b0, exp});
        lcd_e = 1'b0;
        repeat (5) @(negedge clk);
        chk({name, "_oe_lo"}, {31'b0, lcd_d_oe}, 32'd0);
        lcd_rw = 1'b0;
    endtask

    task automatic check_shadow(input logic [4:0] a, input logic [7:0] exp);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        chk($sformatf("shadow[%0d]", a), {24'b0, rd_char}, {24'b0, exp});
    endtask

    initial begin
        // T1: reset state
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_ac", {25'b0, ac}, 32'd0);
        chk("rst_disp", {31'b0, display_on}, 32'd0);
        chk("rst_strobe", {31'b0, wr_strobe}, 32'd0);
        chk("rst_wr", {23'b0, wr_is_data, wr_byte}, 32'd0);
        chk("rst_overrun", {31'b0, overrun}, 32'd0);
        chk("rst_oe", {31'b0, lcd_d_oe}, 32'd0);
        chk("rst_dout", {24'b0, lcd_d_out}, 32'd0);
        for (int i = 0; i < 32; i++) check_shadow(5'(i), 8'h20);

        // T2: set DDRAM address 0, write 'H'
        wr(1'b0, 8'h80);
        chk("busy_len_instr", last_busy_len, 32'd1000);
        wr(1'b1, 8'h48);
        chk("busy_len_data", last_busy_len, 32'd1000);
        chk("t2_ac", {25'b0, ac}, 32'h01);
        check_shadow(5'd0, 8'h48);

        // T3: end of line 1, then an unmapped-but-legal address
        wr(1'b0, 8'hCF);
        chk("t3_ac0", {25'b0, ac}, 32'h4F);
        wr(1'b1, 8'h41);
        chk("t3_ac1", {25'b0, ac}, 32'h50);
        wr(1'b1, 8'h42);
        chk("t3_ac2", {25'b0, ac}, 32'h51);
        check_shadow(5'd31, 8'h41);
        check_shadow(5'd15, 8'h20);

        // T4/T5: clear display, write while busy, instruction read while busy
        bus_write(1'b0, 8'h01, 1'b1);
        bus_write(1'b1, 8'h55, 1'b0);
        chk("t4_overrun", {31'b0, overrun}, 32'd1);
        chk("t4_busy", {31'b0, busy}, 32'd1);
        bus_read(1'b0, 8'h80, "t5_ird");
        wait_idle();
        chk("busy_len_clear", last_busy_len, 32'd41000);
        for (int i = 0; i < 32; i++) check_shadow(5'(i), 8'h20);
        chk("t4_ac", {25'b0, ac}, 32'd0);

        wr(1'b0, 8'h0C);
        chk("disp_on", {31'b0, display_on}, 32'd1);

        // T6: decrement mode, 0x40 -> 0x27, data read steps ac, wrap 0x00 -> 0x67
        wr(1'b0, 8'h04);
        wr(1'b0, 8'hC0);
        wr(1'b1, 8'h5A);
        chk("t6_ac", {25'b0, ac}, 32'h27);
        check_shadow(5'd16, 8'h5A);
        wr(1'b0, 8'hC0);
        bus_read(1'b1, 8'h5A, "t6_drd");
        chk("t6_rd_step", {25'b0, ac}, 32'h27);
        wr(1'b0, 8'h80);
        wr(1'b1, 8'h61);
        chk("dec_wrap", {25'b0, ac}, 32'h67);
        check_shadow(5'd0, 8'h61);

        // Increment from the illegal gap snaps to 0x40, data discarded
        wr(1'b0, 8'h06);
        wr(1'b0, 8'hB0);
        wr(1'b1, 8'h77);
        chk("gap_snap", {25'b0, ac}, 32'h40);

        // CGRAM mode
        wr(1'b0, 8'h40);
        wr(1'b1, 8'h1F);
        wr(1'b0, 8'h40);
`ifdef LCD_RESP_CGRAM_EN
        bus_read(1'b1, 8'h1F, "cg_rd");
`else
        bus_read(1'b1, 8'h00, "cg_rd");
`endif
        chk("cg_ac_kept", {25'b0, ac}, 32'h40);

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        chk("overrun_sticky", {31'b0, overrun}, 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
